// File: rtl/morse_entry_fifo_ctrl.sv
// Morse key-entry controller: builds a dot/dash symbol, decodes it on commit and queues the
// character code in a first-word-fall-through FIFO. Define AUTO_COMMIT_EN for idle auto-commit.
module morse_entry_fifo_ctrl #(
  parameter int MAX_LEN     = 5,
  parameter int DEPTH       = 8,
  parameter int WARN_CYCLES = 100000000,
  parameter int IDLE_CYCLES = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         dot_p,
  input  logic                         dash_p,
  input  logic                         enter_p,
  input  logic                         bksp_p,
  output logic [MAX_LEN-1:0]           sym_bits,
  output logic [$clog2(MAX_LEN+1)-1:0] sym_len,
  output logic                         char_valid,
  output logic [5:0]                   char_code,
  input  logic                         char_ready,
  output logic [$clog2(DEPTH+1)-1:0]   char_count,
  output logic [1:0]                   warn
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(WARN_CYCLES);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WARN_CYCLES - 1);

  typedef enum logic [1:0] {
    WARN_NONE    = 2'b00,
    WARN_LONG    = 2'b01,
    WARN_ILLEGAL = 2'b10,
    WARN_FULL    = 2'b11
  } warn_e;

  if (MAX_LEN < 5 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      WARN_CYCLES < 2 || IDLE_CYCLES < 2) begin : g_param_check
    $error("morse_entry_fifo_ctrl: unsupported parameter set");
  end

  // Returns {legal, code}; bits above the stroke count are always zero.
  function automatic logic [6:0] morse_lookup(input logic [LEN_W-1:0] len,
                                              input logic [4:0] bits);
    logic [6:0] r;
    r = 7'd0;
    if (len <= LEN_W'(5)) begin
      case ({len[2:0], bits})
        8'b001_00000: r = {1'b1, 6'd4};  8'b001_00001: r = {1'b1, 6'd19};
        8'b010_00001: r = {1'b1, 6'd0};  8'b010_00000: r = {1'b1, 6'd8};
        8'b010_00011: r = {1'b1, 6'd12}; 8'b010_00010: r = {1'b1, 6'd13};
        8'b011_00100: r = {1'b1, 6'd3};  8'b011_00110: r = {1'b1, 6'd6};
        8'b011_00101: r = {1'b1, 6'd10}; 8'b011_00111: r = {1'b1, 6'd14};
        8'b011_00010: r = {1'b1, 6'd17}; 8'b011_00000: r = {1'b1, 6'd18};
        8'b011_00001: r = {1'b1, 6'd20}; 8'b011_00011: r = {1'b1, 6'd22};
        8'b100_01000: r = {1'b1, 6'd1};  8'b100_01010: r = {1'b1, 6'd2};
        8'b100_00010: r = {1'b1, 6'd5};  8'b100_00000: r = {1'b1, 6'd7};
        8'b100_00111: r = {1'b1, 6'd9};  8'b100_00100: r = {1'b1, 6'd11};
        8'b100_00110: r = {1'b1, 6'd15}; 8'b100_01101: r = {1'b1, 6'd16};
        8'b100_00001: r = {1'b1, 6'd21}; 8'b100_01001: r = {1'b1, 6'd23};
        8'b100_01011: r = {1'b1, 6'd24}; 8'b100_01100: r = {1'b1, 6'd25};
        8'b101_01111: r = {1'b1, 6'd26}; 8'b101_00111: r = {1'b1, 6'd27};
        8'b101_00011: r = {1'b1, 6'd28}; 8'b101_00001: r = {1'b1, 6'd29};
        8'b101_00000: r = {1'b1, 6'd30}; 8'b101_10000: r = {1'b1, 6'd31};
        8'b101_11000: r = {1'b1, 6'd32}; 8'b101_11100: r = {1'b1, 6'd33};
        8'b101_11110: r = {1'b1, 6'd34}; 8'b101_11111: r = {1'b1, 6'd35};
        default:      r = 7'd0;
      endcase
    end
    return r;
  endfunction

  logic             auto_fire;
  logic             commit, do_bksp, do_stroke, sym_nonzero;
  logic             push, push_ok, pop;
  logic [6:0]       lookup;
  warn_e            new_warn, warn_q;
  logic [TMR_W-1:0] warn_tmr;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [5:0]       mem [DEPTH];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    sym_nonzero = (sym_len != '0);
    commit      = en && (enter_p || auto_fire);
    do_bksp     = en && !commit && bksp_p;
    do_stroke   = en && !commit && !bksp_p && (dot_p || dash_p);
    lookup      = morse_lookup(sym_len, sym_bits[4:0]);
    pop         = char_valid && char_ready;
    push        = commit && sym_nonzero && lookup[6];
    push_ok     = push && ((char_count != CNT_FULL) || pop);
    new_warn    = WARN_NONE;
    if (do_stroke && sym_len == LEN_MAX)        new_warn = WARN_LONG;
    else if (commit && sym_nonzero && !lookup[6]) new_warn = WARN_ILLEGAL;
    else if (push && !push_ok)                  new_warn = WARN_FULL;
  end

  // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_bits <= '0;
      sym_len  <= '0;
    end else if (!en || (commit && sym_nonzero)) begin
      sym_bits <= '0;
      sym_len  <= '0;
    end else if (do_bksp && sym_nonzero) begin
      sym_bits <= sym_bits >> 1;
      sym_len  <= sym_len - 1'b1;
    end else if (do_stroke && sym_len != LEN_MAX) begin
      sym_bits <= {sym_bits[MAX_LEN-2:0], dash_p};
      sym_len  <= sym_len + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      char_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   char_count <= char_count + 1'b1;
        2'b01:   char_count <= char_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= lookup[5:0];
  end

  assign char_valid = (char_count != '0);
  assign char_code  = char_valid ? mem[rd_ptr] : 6'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q   <= WARN_NONE;
      warn_tmr <= '0;
    end else if (new_warn != WARN_NONE) begin
      warn_q   <= new_warn;
      warn_tmr <= TMR_LOAD;
    end else if (warn_q != WARN_NONE) begin
      if (warn_tmr == '0) warn_q   <= WARN_NONE;
      else                warn_tmr <= warn_tmr - 1'b1;
    end
  end

  assign warn = warn_q;

`ifdef AUTO_COMMIT_EN
  localparam int IDL_W = $clog2(IDLE_CYCLES);
  logic [IDL_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en || commit || do_bksp || do_stroke || !sym_nonzero) idle_cnt <= '0;
    else                                                               idle_cnt <= idle_cnt + 1'b1;
  end

  assign auto_fire = sym_nonzero && (idle_cnt == IDL_W'(IDLE_CYCLES - 1));
`else
  assign auto_fire = 1'b0;
`endif

endmodule

// File: tb/tb_morse_entry_fifo_ctrl.sv
// Self-checking bench: string/queue reference model compared every cycle plus directed literal checks.
module tb_morse_entry_fifo_ctrl;
  localparam int MAX_LEN = 5, DEPTH = 4, WARN_CYCLES = 16, IDLE_CYCLES = 32;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic       dot_p = 1'b0, dash_p = 1'b0, enter_p = 1'b0, bksp_p = 1'b0, char_ready = 1'b0;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       char_valid;
  logic [5:0] char_code;
  logic [2:0] char_count;
  logic [1:0] warn;

  int n_checks = 0, n_fail = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  morse_entry_fifo_ctrl #(
    .MAX_LEN(MAX_LEN), .DEPTH(DEPTH), .WARN_CYCLES(WARN_CYCLES), .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dot_p(dot_p), .dash_p(dash_p), .enter_p(enter_p),
    .bksp_p(bksp_p), .sym_bits(sym_bits), .sym_len(sym_len), .char_valid(char_valid),
    .char_code(char_code), .char_ready(char_ready), .char_count(char_count), .warn(warn)
  );

  // Code index -> Morse pattern: A..Z, then digits 1..9, 0.
  string pat [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--..", ".----", "..---", "...--",
                      "....-", ".....", "-....", "--...", "---..", "----.", "-----"};

  string m_sym = "";
  int    m_q[$];
  int    m_warn = 0, m_wleft = 0, m_quiet = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_code(input string s);
    for (int i = 0; i < 36; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  function automatic int sym_value(input string s);
    int v = 0;
    for (int i = 0; i < s.len(); i++) v = v * 2 + ((s.getc(i) == "-") ? 1 : 0);
    return v;
  endfunction

  // Reference model, advanced on each rising edge from the inputs it sees there.
  always @(posedge clk) begin
    int code, nw;
    bit pop, push, commit, auto_c, stroke_taken;
    if (rst) begin
      m_sym = ""; m_q.delete(); m_warn = 0; m_wleft = 0; m_quiet = 0;
    end else begin
      pop = (m_q.size() != 0) && char_ready;
      push = 1'b0; nw = 0; code = 0; stroke_taken = 1'b0;
`ifdef AUTO_COMMIT_EN
      auto_c = (m_sym.len() != 0) && (m_quiet == IDLE_CYCLES - 1);
`else
      auto_c = 1'b0;
`endif
      commit = en && (enter_p || auto_c);
      if (!en) m_sym = "";
      else if (commit) begin
        if (m_sym.len() != 0) begin
          code = find_code(m_sym);
          if (code < 0)                           nw = 2;
          else if (m_q.size() == DEPTH && !pop)   nw = 3;
          else                                    push = 1'b1;
          m_sym = "";
        end
      end else if (bksp_p) begin
        stroke_taken = 1'b1;
        if (m_sym.len() == 1)     m_sym = "";
        else if (m_sym.len() > 1) m_sym = m_sym.substr(0, m_sym.len() - 2);
      end else if (dash_p || dot_p) begin
        stroke_taken = 1'b1;
        if (m_sym.len() >= MAX_LEN) nw = 1;
        else if (dash_p)            m_sym = {m_sym, "-"};
        else                        m_sym = {m_sym, "."};
      end
      if (!en || commit || stroke_taken || m_sym.len() == 0) m_quiet = 0;
      else m_quiet++;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(code);
      if (nw != 0) begin
        m_warn = nw; m_wleft = WARN_CYCLES;
      end else if (m_wleft > 0) begin
        m_wleft--;
        if (m_wleft == 0) m_warn = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cmp_sym_len",    32'(sym_len),    32'(m_sym.len()));
      check("cmp_sym_bits",   32'(sym_bits),   32'(sym_value(m_sym)));
      check("cmp_char_count", 32'(char_count), 32'(m_q.size()));
      check("cmp_char_valid", 32'(char_valid), 32'(m_q.size() != 0));
      check("cmp_char_code",  32'(char_code),  32'((m_q.size() != 0) ? m_q[0] : 0));
      check("cmp_warn",       32'(warn),       32'(m_warn));
    end
  end

  task automatic ev(input bit d, input bit s, input bit e, input bit b);
    dot_p = d; dash_p = s; enter_p = e; bksp_p = b;
    @(negedge clk);
    dot_p = 1'b0; dash_p = 1'b0; enter_p = 1'b0; bksp_p = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strokes(input string s);
    for (int i = 0; i < s.len(); i++) ev(s.getc(i) == ".", s.getc(i) == "-", 1'b0, 1'b0);
  endtask

  task automatic commit_sym(input string s);
    strokes(s);
    ev(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    checking = 1'b1;
    check("reset_sym_len", 32'(sym_len), 0);
    check("reset_count", 32'(char_count), 0);
    check("reset_valid", 32'(char_valid), 0);
    check("reset_code", 32'(char_code), 0);
    check("reset_warn", 32'(warn), 0);

    // A: dot, dash, enter
    strokes(".-");
    check("a_sym_bits", 32'(sym_bits), 32'h1);
    check("a_sym_len", 32'(sym_len), 2);
    ev(1'b0, 1'b0, 1'b1, 1'b0);
    check("a_valid", 32'(char_valid), 1);
    check("a_code", 32'(char_code), 0);
    char_ready = 1'b1; idle(1); char_ready = 1'b0;
    check("a_drained", 32'(char_count), 0);

    // '0' and too-long warning
    strokes("-----");
    check("zero_bits", 32'(sym_bits), 32'h1f);
    strokes("-");
    check("long_warn", 32'(warn), 1);
    check("long_len", 32'(sym_len), 5);
    ev(1'b0, 1'b0, 1'b1, 1'b0);
    check("zero_code", 32'(char_code), 35);
    idle(14);
    check("long_warn_held", 32'(warn), 1);
    idle(1);
    check("long_warn_clear", 32'(warn), 0);
    char_ready = 1'b1; idle(1); char_ready = 1'b0;

    // illegal ----
    commit_sym("----");
    check("illegal_warn", 32'(warn), 2);
    check("illegal_count", 32'(char_count), 0);
    check("illegal_len", 32'(sym_len), 0);
    idle(16);

    // FIFO full, overflow, then push+pop at full
    commit_sym("."); commit_sym("-"); commit_sym(".."); commit_sym("--");
    check("full_count", 32'(char_count), 4);
    commit_sym(".-");
    check("full_warn", 32'(warn), 3);
    check("full_count_kept", 32'(char_count), 4);
    idle(16);
    check("full_warn_clear", 32'(warn), 0);
    strokes("-.");
    char_ready = 1'b1;
    ev(1'b0, 1'b0, 1'b1, 1'b0);
    char_ready = 1'b0;
    check("pushpop_count", 32'(char_count), 4);
    check("pushpop_warn", 32'(warn), 0);
    char_ready = 1'b1;
    check("order_0", 32'(char_code), 19); idle(1);
    check("order_1", 32'(char_code), 8);  idle(1);
    check("order_2", 32'(char_code), 12); idle(1);
    check("order_3", 32'(char_code), 13); idle(1);
    char_ready = 1'b0;
    check("order_empty", 32'(char_count), 0);

    // backspace underflow
    strokes(".-");
    ev(1'b0, 1'b0, 1'b0, 1'b1); check("bksp_1", 32'(sym_len), 1);
    ev(1'b0, 1'b0, 1'b0, 1'b1); check("bksp_0", 32'(sym_len), 0);
    ev(1'b0, 1'b0, 1'b0, 1'b1); check("bksp_under", 32'(sym_len), 0);
    check("bksp_warn", 32'(warn), 0);
    ev(1'b0, 1'b0, 1'b1, 1'b0);
    check("empty_enter", 32'(char_count), 0);
    check("empty_enter_warn", 32'(warn), 0);

    // idle auto-commit of B
    strokes("-..");
    idle(31);
    check("idle_not_yet", 32'(char_count), 0);
    idle(1);
`ifdef AUTO_COMMIT_EN
    check("auto_count", 32'(char_count), 1);
    check("auto_code", 32'(char_code), 1);
    check("auto_len", 32'(sym_len), 0);
`else
    check("noauto_count", 32'(char_count), 0);
    check("noauto_len", 32'(sym_len), 3);
`endif
    char_ready = 1'b1; idle(1); char_ready = 1'b0;

    // enable low flushes the symbol and ignores strokes
    en = 1'b0;
    ev(1'b1, 1'b0, 1'b0, 1'b0);
    check("en_flush", 32'(sym_len), 0);
    en = 1'b1;

    // priority: bksp over strokes, enter over everything
    strokes(".");
    ev(1'b1, 1'b1, 1'b0, 1'b1);
    check("prio_bksp", 32'(sym_len), 0);
    strokes("-");
    ev(1'b1, 1'b1, 1'b1, 1'b1);
    check("prio_enter", 32'(char_code), 19);
    check("prio_enter_len", 32'(sym_len), 0);

    // reset mid-operation discards FIFO
    commit_sym(".");
    strokes("-");
    rst = 1'b1; idle(1); rst = 1'b0;
    check("midrst_count", 32'(char_count), 0);
    check("midrst_len", 32'(sym_len), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
